// File: rtl/tick_counter_pkg.sv
// Shared constants and helpers for the tick up/down counter.
// Holds the active-low 7-segment digit patterns {g,f,e,d,c,b,a}.
package tick_counter_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronises the divided clock into the system domain and
// emits a single-cycle pulse for each of its rising edges.
module tick_edge_sync
    import tick_counter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shift chain plus history flop; all ones so a held-high input is not an edge
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tick_i};
        prev_d = sync_out;
    end

    // Synchroniser and history registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse_o = sync_out & ~prev_q;

endmodule

// File: rtl/tick_updown_counter.sv
// Up/down modulo-2^WIDTH counter stepped by rising edges of a
// divided clock, with a registered active-low hex display.
module tick_updown_counter
    import tick_counter_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             up_down,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic [6:0]       seg
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             tick_pulse;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       digit;

    tick_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clock_in),
        .rst_ni  (rst_n),
        .tick_i  (tick_in),
        .pulse_o (tick_pulse)
    );

    assign digit = 4'(count_q);

    // Priority mux: load, then an unheld tick step, else hold
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        seg_d   = hex_to_seg(digit);
        if (load) begin
            count_d = load_value;
        end else if (tick_pulse && !hold) begin
            if (up_down) begin
                count_d = count_q + 1'b1;
                wrap_d  = (count_q == CNT_MAX);
            end else begin
                count_d = count_q - 1'b1;
                wrap_d  = (count_q == '0);
            end
        end
    end

    // Counter, wrap pulse and display registers
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= SEG_0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_tick_updown_counter.sv
// Directed bench for tick_updown_counter (WIDTH=3, SYNC_STAGES=2).
// Ticks follow a divide-by-4 shape: 2 clocks high, 2 low.
module tb_tick_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       tick_in;
    logic       up_down;
    logic       hold;
    logic       load;
    logic [2:0] load_value;
    logic [2:0] count;
    logic       wrap;
    logic [6:0] seg;

    int n_cmp;
    int n_bad;

    tick_updown_counter #(
        .WIDTH       (3),
        .SYNC_STAGES (2)
    ) dut (
        .clock_in   (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .up_down    (up_down),
        .hold       (hold),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .wrap       (wrap),
        .seg        (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) edge1();
    endtask

    // One divide-by-4 period; reports wrap cycles, count before the
    // step edge and seg on the step edge (still the old digit).
    task automatic tick_once(output int wraps, output logic [2:0] c2,
                             output logic [6:0] s3);
        wraps = 0;
        c2 = 'x;
        s3 = 'x;
        tick_in = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            edge1();
            wraps += int'(wrap);
            if (e == 2) begin
                c2 = count;
                tick_in = 1'b0;
            end
            if (e == 3) s3 = seg;
        end
    endtask

    task automatic do_load(input logic [2:0] v);
        load = 1'b1;
        load_value = v;
        edge1();
        load = 1'b0;
        chk("load_count", count, v);
        edge1();
    endtask

    logic [2:0] exp_cnt [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                3'd6, 3'd7, 3'd0, 3'd1};
    int         wr;
    logic [2:0] c2;
    logic [6:0] s3;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        tick_in = 1'b1;
        up_down = 1'b1;
        hold = 1'b0;
        load = 1'b0;
        load_value = '0;

        edges(3);
        chk("rst_count", count, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_seg", seg, 7'b1000000);

        rst_n = 1'b1;
        edges(4);
        chk("high_at_rel_count", count, 0);
        chk("high_at_rel_seg", seg, 7'b1000000);

        tick_in = 1'b0;
        edges(3);
        tick_in = 1'b1;
        edges(2);
        chk("lat_edge2", count, 0);
        edge1();
        chk("lat_edge3", count, 1);
        chk("lat_wrap", wrap, 0);
        edge1();
        chk("lat_seg", seg, 7'b1111001);
        tick_in = 1'b0;
        edges(3);

        do_load(3'd0);
        for (int i = 0; i < 9; i++) begin
            tick_once(wr, c2, s3);
            chk($sformatf("up%0d_count", i), count, exp_cnt[i]);
            chk($sformatf("up%0d_wraps", i), wr, (i == 7) ? 1 : 0);
        end

        do_load(3'd0);
        up_down = 1'b0;
        tick_once(wr, c2, s3);
        chk("dn_wrap_count", count, 7);
        chk("dn_wrap_pulse", wr, 1);
        tick_once(wr, c2, s3);
        chk("dn_next_count", count, 6);
        chk("dn_next_pulse", wr, 0);

        tick_in = 1'b1;
        edges(2);
        tick_in = 1'b0;
        load = 1'b1;
        load_value = 3'd5;
        edge1();
        load = 1'b0;
        chk("ld_win_count", count, 5);
        chk("ld_win_wrap", wrap, 0);
        edge1();
        chk("ld_win_seg", seg, 7'b0010010);
        edges(2);
        chk("ld_win_lost", count, 5);

        up_down = 1'b1;
        tick_once(wr, c2, s3);
        chk("after_ld_pre", c2, 5);
        chk("after_ld_seglag", s3, 7'b0010010);
        chk("after_ld_count", count, 6);
        chk("after_ld_seg", seg, 7'b0000010);

        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_once(wr, c2, s3);
            chk($sformatf("hold%0d_count", i), count, 6);
            chk($sformatf("hold%0d_wraps", i), wr, 0);
        end
        hold = 1'b0;
        edges(2);
        chk("unhold_idle", count, 6);
        tick_once(wr, c2, s3);
        chk("unhold_step", count, 7);
        chk("unhold_seg", seg, 7'b1111000);

        do_load(3'd4);
        chk("pre_rst_seg", seg, 7'b0011001);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_wrap", wrap, 0);
        chk("async_rst_seg", seg, 7'b1000000);
        edge1();
        rst_n = 1'b1;
        edges(2);
        chk("post_rst_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
